// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared types and constants for the CPU bus arbiter
// Purpose: state encoding, owner indices, bus widths and default timeout
// used by cpu_bus_arbiter and cpu_bus_timeout_ctr.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_t;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/cpu_bus_timeout_ctr.sv
// rtl/cpu_bus_timeout_ctr.sv - grant-cycle counter that flags transaction timeout
// Purpose: counts grant cycles without ack; expire is high in the cycle the
// count sits at LIMIT-1 while still enabled.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force count to zero (held while the arbiter is idle)
//   enable     : count this cycle (granted and no ack)
//   expire     : combinational, timeout reached this cycle
module cpu_bus_timeout_ctr #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [15:0] LAST = 16'(LIMIT - 1);

    logic [15:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 16'd0;
        end else if (clear) begin
            count <= 16'd0;
        end else if (enable) begin
            count <= count + 16'd1;
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/cpu_bus_arbiter.sv
// rtl/cpu_bus_arbiter.sv - two-requester round-robin bus arbiter (fetch m0, data m1)
// Purpose: grants the shared bus to one requester at a time, registers the
// winner's request onto the bus and routes ack/read data back to the owner.
// Optional timeout abort enabled by defining CPU_BUS_ARB_TIMEOUT_EN.
// Ports:
//   clk_i, rst_n_i                  : clock, asynchronous active-low reset
//   mN_stb/we/adr/dat/sel_i         : requester N transaction request
//   mN_ack/err/dat_o                : requester N completion, timeout error, read data
//   bus_cyc/stb/we/adr/dat/sel_o    : registered bus request
//   bus_gnt_o                       : one-hot current owner
//   bus_ack_i, bus_dat_i            : bus completion and read data
module cpu_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic             clk_i,
    input  logic             rst_n_i,

    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    input  logic [SEL_W-1:0] m0_sel_i,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    output logic [DAT_W-1:0] m0_dat_o,

    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    input  logic [SEL_W-1:0] m1_sel_i,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic [DAT_W-1:0] m1_dat_o,

    output logic             bus_cyc_o,
    output logic             bus_stb_o,
    output logic             bus_we_o,
    output logic [ADR_W-1:0] bus_adr_o,
    output logic [DAT_W-1:0] bus_dat_o,
    output logic [SEL_W-1:0] bus_sel_o,
    output logic [1:0]       bus_gnt_o,
    input  logic             bus_ack_i,
    input  logic [DAT_W-1:0] bus_dat_i
);

    arb_state_t state;
    logic       last_owner;
    logic       cur_owner;

    assign cur_owner = (state == ST_GNT1) ? OWNER_M1 : OWNER_M0;

    // m0 wins when alone, or on contention when m1 was served last.
    logic pick_m0;
    assign pick_m0 = m0_stb_i && (!m1_stb_i || (last_owner == OWNER_M1));

`ifdef CPU_BUS_ARB_TIMEOUT_EN
    logic tmo_clear;
    logic tmo_enable;
    logic tmo_expire;

    // Held clear while idle so the count starts at zero on the grant edge.
    assign tmo_clear  = (state == ST_IDLE);
    assign tmo_enable = (state != ST_IDLE) && !bus_ack_i;

    cpu_bus_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk    (clk_i),
        .rst_n  (rst_n_i),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .expire (tmo_expire)
    );
`else
    assign m0_err_o = 1'b0;
    assign m1_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= ST_IDLE;
            last_owner <= OWNER_M1;
            bus_cyc_o  <= 1'b0;
            bus_stb_o  <= 1'b0;
            bus_we_o   <= 1'b0;
            bus_adr_o  <= '0;
            bus_dat_o  <= '0;
            bus_sel_o  <= '0;
            bus_gnt_o  <= 2'b00;
`ifdef CPU_BUS_ARB_TIMEOUT_EN
            m0_err_o   <= 1'b0;
            m1_err_o   <= 1'b0;
`endif
        end else begin
`ifdef CPU_BUS_ARB_TIMEOUT_EN
            m0_err_o <= 1'b0;
            m1_err_o <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (pick_m0) begin
                        state     <= ST_GNT0;
                        bus_cyc_o <= 1'b1;
                        bus_stb_o <= 1'b1;
                        bus_we_o  <= m0_we_i;
                        bus_adr_o <= m0_adr_i;
                        bus_dat_o <= m0_dat_i;
                        bus_sel_o <= m0_sel_i;
                        bus_gnt_o <= 2'b01;
                    end else if (m1_stb_i) begin
                        state     <= ST_GNT1;
                        bus_cyc_o <= 1'b1;
                        bus_stb_o <= 1'b1;
                        bus_we_o  <= m1_we_i;
                        bus_adr_o <= m1_adr_i;
                        bus_dat_o <= m1_dat_i;
                        bus_sel_o <= m1_sel_i;
                        bus_gnt_o <= 2'b10;
                    end
                end
                ST_GNT0, ST_GNT1: begin
                    // Bus fields stay latched; only ack (or timeout) ends the grant.
                    if (bus_ack_i) begin
                        state      <= ST_IDLE;
                        last_owner <= cur_owner;
                        bus_cyc_o  <= 1'b0;
                        bus_stb_o  <= 1'b0;
                        bus_gnt_o  <= 2'b00;
                    end
`ifdef CPU_BUS_ARB_TIMEOUT_EN
                    else if (tmo_expire) begin
                        state      <= ST_IDLE;
                        last_owner <= cur_owner;
                        bus_cyc_o  <= 1'b0;
                        bus_stb_o  <= 1'b0;
                        bus_gnt_o  <= 2'b00;
                        if (cur_owner == OWNER_M1) begin
                            m1_err_o <= 1'b1;
                        end else begin
                            m0_err_o <= 1'b1;
                        end
                    end
`endif
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Ack and read data are steered only to the current owner; in IDLE gnt is 00.
    assign m0_ack_o = bus_ack_i & bus_gnt_o[0];
    assign m1_ack_o = bus_ack_i & bus_gnt_o[1];
    assign m0_dat_o = bus_gnt_o[0] ? bus_dat_i : '0;
    assign m1_dat_o = bus_gnt_o[1] ? bus_dat_i : '0;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb/tb_cpu_bus_arbiter.sv - directed self-checking bench for cpu_bus_arbiter
module tb_cpu_bus_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        m0_stb_i, m0_we_i;
    logic [31:0] m0_adr_i, m0_dat_i;
    logic [3:0]  m0_sel_i;
    logic        m0_ack_o, m0_err_o;
    logic [31:0] m0_dat_o;
    logic        m1_stb_i, m1_we_i;
    logic [31:0] m1_adr_i, m1_dat_i;
    logic [3:0]  m1_sel_i;
    logic        m1_ack_o, m1_err_o;
    logic [31:0] m1_dat_o;
    logic        bus_cyc_o, bus_stb_o, bus_we_o;
    logic [31:0] bus_adr_o, bus_dat_o;
    logic [3:0]  bus_sel_o;
    logic [1:0]  bus_gnt_o;
    logic        bus_ack_i;
    logic [31:0] bus_dat_i;

    int checks = 0;
    int fails  = 0;

    always #5 clk_i = ~clk_i;

    cpu_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
        .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
        .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
        .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
        .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
        .bus_adr_o(bus_adr_o), .bus_dat_o(bus_dat_o), .bus_sel_o(bus_sel_o),
        .bus_gnt_o(bus_gnt_o), .bus_ack_i(bus_ack_i), .bus_dat_i(bus_dat_i)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        m0_stb_i = 0; m0_we_i = 0; m0_adr_i = 0; m0_dat_i = 0; m0_sel_i = 0;
        m1_stb_i = 0; m1_we_i = 0; m1_adr_i = 0; m1_dat_i = 0; m1_sel_i = 0;
        bus_ack_i = 0; bus_dat_i = 0;
        tick();
        tick();
        checks++;
        if ({bus_cyc_o, bus_stb_o, bus_we_o, bus_gnt_o} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: cyc/stb/we/gnt=%b expected 00000",
                     {bus_cyc_o, bus_stb_o, bus_we_o, bus_gnt_o});
        end
        checks++;
        if ({bus_adr_o, bus_dat_o, bus_sel_o, m0_err_o, m1_err_o} !== 70'd0) begin
            fails++;
            $display("FAIL reset_data: adr=%h dat=%h sel=%h err=%b%b expected zeros",
                     bus_adr_o, bus_dat_o, bus_sel_o, m0_err_o, m1_err_o);
        end
        rst_n_i = 1'b1;
    endtask

    task automatic test_round_robin();
        m0_stb_i = 1; m0_adr_i = 32'h0000_0100; m0_sel_i = 4'hF;
        m1_stb_i = 1; m1_adr_i = 32'h0000_0200; m1_sel_i = 4'hF;
        tick();
        checks++;
        if (bus_gnt_o !== 2'b01) begin
            fails++;
            $display("FAIL rr_first: gnt=%b expected 01", bus_gnt_o);
        end
        bus_ack_i = 1;
        tick();
        bus_ack_i = 0;
        checks++;
        if (bus_gnt_o !== 2'b00 || bus_cyc_o !== 1'b0) begin
            fails++;
            $display("FAIL rr_idle_gap: gnt=%b cyc=%b expected 00 0", bus_gnt_o, bus_cyc_o);
        end
        tick();
        checks++;
        if (bus_gnt_o !== 2'b10 || bus_adr_o !== 32'h0000_0200) begin
            fails++;
            $display("FAIL rr_second: gnt=%b adr=%h expected 10 00000200", bus_gnt_o, bus_adr_o);
        end
        bus_ack_i = 1;
        tick();
        bus_ack_i = 0;
        tick();
        checks++;
        if (bus_gnt_o !== 2'b01) begin
            fails++;
            $display("FAIL rr_third: gnt=%b expected 01", bus_gnt_o);
        end
        m0_stb_i = 0; m1_stb_i = 0;
        bus_ack_i = 1;
        tick();
        bus_ack_i = 0;
    endtask

    task automatic test_single_read();
        m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h0000_1000; m0_sel_i = 4'hF;
        #1;
        checks++;
        if (bus_stb_o !== 1'b0) begin
            fails++;
            $display("FAIL read_pre_grant: stb=%b expected 0", bus_stb_o);
        end
        tick();
        checks++;
        if (bus_gnt_o !== 2'b01 || bus_stb_o !== 1'b1 || bus_adr_o !== 32'h0000_1000 || bus_we_o !== 1'b0) begin
            fails++;
            $display("FAIL read_grant: gnt=%b stb=%b adr=%h we=%b expected 01 1 00001000 0",
                     bus_gnt_o, bus_stb_o, bus_adr_o, bus_we_o);
        end
        m0_stb_i = 0;
        tick();
        tick();
        bus_ack_i = 1; bus_dat_i = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL read_ack: m0_ack=%b m0_dat=%h expected 1 deadbeef", m0_ack_o, m0_dat_o);
        end
        checks++;
        if (m1_ack_o !== 1'b0 || m1_dat_o !== 32'h0) begin
            fails++;
            $display("FAIL read_nonowner: m1_ack=%b m1_dat=%h expected 0 00000000", m1_ack_o, m1_dat_o);
        end
        tick();
        bus_ack_i = 0; bus_dat_i = 0;
        checks++;
        if (bus_cyc_o !== 1'b0 || bus_gnt_o !== 2'b00) begin
            fails++;
            $display("FAIL read_release: cyc=%b gnt=%b expected 0 00", bus_cyc_o, bus_gnt_o);
        end
    endtask

    task automatic test_hold();
        m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 32'h0000_2004;
        m1_dat_i = 32'h1234_5678; m1_sel_i = 4'b0011;
        tick();
        checks++;
        if (bus_gnt_o !== 2'b10 || bus_we_o !== 1'b1 || bus_dat_o !== 32'h1234_5678 || bus_sel_o !== 4'b0011) begin
            fails++;
            $display("FAIL hold_grant: gnt=%b we=%b dat=%h sel=%b expected 10 1 12345678 0011",
                     bus_gnt_o, bus_we_o, bus_dat_o, bus_sel_o);
        end
        m1_adr_i = 32'hFFFF_0000; m1_dat_i = 32'h0; m1_sel_i = 4'hF; m1_stb_i = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus_adr_o !== 32'h0000_2004 || bus_stb_o !== 1'b1) begin
                fails++;
                $display("FAIL hold_stable[%0d]: adr=%h stb=%b expected 00002004 1", i, bus_adr_o, bus_stb_o);
            end
        end
        bus_ack_i = 1;
        #1;
        checks++;
        if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin
            fails++;
            $display("FAIL hold_ack: m1_ack=%b m0_ack=%b expected 1 0", m1_ack_o, m0_ack_o);
        end
        tick();
        bus_ack_i = 0;
    endtask

    task automatic test_idle_ack();
        bus_ack_i = 1;
        #1;
        checks++;
        if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin
            fails++;
            $display("FAIL idle_ack_out: m0_ack=%b m1_ack=%b expected 0 0", m0_ack_o, m1_ack_o);
        end
        tick();
        checks++;
        if (bus_cyc_o !== 1'b0 || bus_gnt_o !== 2'b00) begin
            fails++;
            $display("FAIL idle_ack_state: cyc=%b gnt=%b expected 0 00", bus_cyc_o, bus_gnt_o);
        end
        bus_ack_i = 0;
    endtask

`ifdef CPU_BUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 32'h0000_3000;
        tick();
        m1_stb_i = 0;
        for (int i = 1; i < 8; i++) begin
            tick();
            checks++;
            if (bus_stb_o !== 1'b1 || m1_err_o !== 1'b0) begin
                fails++;
                $display("FAIL tmo_wait[%0d]: stb=%b err=%b expected 1 0", i, bus_stb_o, m1_err_o);
            end
        end
        tick();
        checks++;
        if (m1_err_o !== 1'b1 || m0_err_o !== 1'b0 || bus_stb_o !== 1'b0 || bus_gnt_o !== 2'b00) begin
            fails++;
            $display("FAIL tmo_expire: m1_err=%b m0_err=%b stb=%b gnt=%b expected 1 0 0 00",
                     m1_err_o, m0_err_o, bus_stb_o, bus_gnt_o);
        end
        tick();
        checks++;
        if (m1_err_o !== 1'b0) begin
            fails++;
            $display("FAIL tmo_pulse: m1_err=%b expected 0", m1_err_o);
        end
        m1_stb_i = 1;
        tick();
        m1_stb_i = 0;
        for (int i = 1; i < 8; i++) tick();
        bus_ack_i = 1;
        #1;
        checks++;
        if (m1_ack_o !== 1'b1) begin
            fails++;
            $display("FAIL tmo_ack_same: m1_ack=%b expected 1", m1_ack_o);
        end
        tick();
        bus_ack_i = 0;
        checks++;
        if (m1_err_o !== 1'b0 || bus_gnt_o !== 2'b00) begin
            fails++;
            $display("FAIL tmo_ack_noerr: m1_err=%b gnt=%b expected 0 00", m1_err_o, bus_gnt_o);
        end
    endtask
`else
    task automatic test_timeout();
        m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 32'h0000_3000;
        tick();
        m1_stb_i = 0;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (bus_stb_o !== 1'b1 || bus_gnt_o !== 2'b10 || m1_err_o !== 1'b0) begin
            fails++;
            $display("FAIL no_tmo_wait: stb=%b gnt=%b err=%b expected 1 10 0", bus_stb_o, bus_gnt_o, m1_err_o);
        end
        bus_ack_i = 1;
        tick();
        bus_ack_i = 0;
    endtask
`endif

    task automatic test_async_reset();
        m0_stb_i = 1; m0_adr_i = 32'h0000_4000;
        tick();
        checks++;
        if (bus_gnt_o !== 2'b01) begin
            fails++;
            $display("FAIL areset_grant: gnt=%b expected 01", bus_gnt_o);
        end
        m0_stb_i = 0;
        #2;
        rst_n_i = 1'b0;
        #1;
        checks++;
        if (bus_stb_o !== 1'b0 || bus_cyc_o !== 1'b0 || bus_gnt_o !== 2'b00 || bus_adr_o !== 32'h0) begin
            fails++;
            $display("FAIL areset_drop: stb=%b cyc=%b gnt=%b adr=%h expected 0 0 00 00000000",
                     bus_stb_o, bus_cyc_o, bus_gnt_o, bus_adr_o);
        end
        #1;
        rst_n_i = 1'b1;
        bus_ack_i = 1;
        #1;
        checks++;
        if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin
            fails++;
            $display("FAIL areset_late_ack: m0_ack=%b m1_ack=%b expected 0 0", m0_ack_o, m1_ack_o);
        end
        tick();
        bus_ack_i = 0;
        m0_stb_i = 1; m1_stb_i = 1;
        tick();
        checks++;
        if (bus_gnt_o !== 2'b01) begin
            fails++;
            $display("FAIL areset_last_owner: gnt=%b expected 01", bus_gnt_o);
        end
        m0_stb_i = 0; m1_stb_i = 0;
        bus_ack_i = 1;
        tick();
        bus_ack_i = 0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_read();
        test_hold();
        test_idle_ack();
        test_timeout();
        test_async_reset();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/cpu_bus_arbiter.md
CPU_BUS_ARBITER -- requirements
Module: cpu_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning grant-cycle limit before a transaction is aborted (range 2..65535).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n_i, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have ports m0_stb_i / m1_stb_i, input, 1, request strobes (m0 = instruction fetch, m1 = data).
REQ-005 SHALL have ports mN_we_i (1), mN_adr_i (32), mN_dat_i (32) and mN_sel_i (4), all inputs, giving the write enable, address, write data and byte selects of each requester.
REQ-006 SHALL have ports mN_ack_o (1), mN_err_o (1) and mN_dat_o (32), all outputs, giving per-requester completion, timeout error and read data.
REQ-007 SHALL have bus outputs bus_cyc_o (1), bus_stb_o (1), bus_we_o (1), bus_adr_o (32), bus_dat_o (32), bus_sel_o (4) and bus_gnt_o (2, one-hot owner).
REQ-008 SHALL have bus inputs bus_ack_i (1) and bus_dat_i (32).

Function
REQ-009 SHALL implement the states IDLE, GNT0 and GNT1.
REQ-010 In IDLE, a single requester with stb high SHALL cause a move to its GNT state at the next edge.
REQ-011 If both stb are high in IDLE, the requester not served last SHALL win (round-robin); the last-owner register SHALL reset to 1, so m0 wins first.
REQ-012 On the IDLE->GNTn edge, mN_we/adr/dat/sel SHALL be registered onto the bus_* outputs, and bus_cyc_o, bus_stb_o and bus_gnt_o[n] SHALL be set. Grant latency is therefore 1 cycle from stb to bus_stb_o.
REQ-013 The bus_* outputs SHALL hold stable throughout GNTn regardless of requester input changes; a requester dropping stb before ack SHALL NOT abort the transaction.
REQ-014 mN_ack_o SHALL equal bus_ack_i & bus_gnt_o[n] combinationally, and the non-owner ack SHALL be 0.
REQ-015 mN_dat_o SHALL carry bus_dat_i when n is the owner and 0 otherwise.
REQ-016 bus_ack_i in GNTn SHALL cause a return to IDLE at the next edge, clear cyc/stb/gnt, and update last-owner to n. This gives one idle cycle between back-to-back grants.
REQ-017 bus_ack_i in IDLE SHALL be ignored: no ack to any requester and no state change.
REQ-018 A requester whose stb stays high after its ack SHALL be treated as a new request at IDLE, subject to round-robin.

Reset
REQ-019 Assertion of rst_n_i SHALL immediately force the following, including mid-transaction: state IDLE, bus_cyc_o/bus_stb_o/bus_we_o = 0, bus_adr_o/bus_dat_o = 0, bus_sel_o = 0, bus_gnt_o = 00, mN_err_o = 0, timeout counter 0, last-owner 1.
REQ-020 After rst_n_i deasserts, the first arbitration decision SHALL occur on the first rising edge.

Configuration
REQ-021 Macro CPU_BUS_ARB_TIMEOUT_EN defined: a counter SHALL clear on entry to GNTn and increment each GNTn cycle without ack.
REQ-022 With the macro defined, when the counter reaches TIMEOUT_CYCLES-1 with no ack, mN_err_o SHALL pulse for one cycle at the next edge, bus signals SHALL clear and the state SHALL return to IDLE, with last-owner set to n.
REQ-023 With the macro defined, bus_ack_i in the same cycle as timeout expiry SHALL take precedence: ack delivered, err not asserted.
REQ-024 Macro undefined: no counter SHALL exist, mN_err_o SHALL be tied 0, and GNTn SHALL wait for ack indefinitely; the port list SHALL be unchanged.

Structure
REQ-025 Shared package cpu_bus_pkg SHALL hold the state typedef (IDLE/GNT0/GNT1), the owner index constants, the bus width constants (ADR 32, DAT 32, SEL 4) and the default TIMEOUT_CYCLES.
REQ-026 The timeout counter SHALL be a sub-module cpu_bus_timeout_ctr (clear, enable, expire outputs), instantiated only under CPU_BUS_ARB_TIMEOUT_EN.

Verification
REQ-027 m0 read adr 0x0000_1000 alone; bus_ack_i 3 cycles after bus_stb_o, bus_dat_i 0xDEAD_BEEF -> bus_gnt_o=01 one cycle after stb, m0_ack_o=1 with m0_dat_o=0xDEAD_BEEF, m1_ack_o=0.
REQ-028 m0 and m1 request together immediately after reset -> m0 granted first; m1 granted at IDLE+1 after m0's ack; third simultaneous request goes to m0.
REQ-029 m1 write adr 0x0000_2004, dat 0x1234_5678, sel 4'b0011; m1 changes adr at grant+1 -> bus_adr_o stays 0x0000_2004 until ack.
REQ-030 TIMEOUT_EN defined, TIMEOUT_CYCLES=8, no ack -> m1_err_o pulses 8 cycles after grant and bus_stb_o drops; a variant with ack on cycle 8 -> ack delivered, no err.
REQ-031 rst_n_i low mid-GNT0 -> bus_stb_o/bus_cyc_o/bus_gnt_o drop without a clock edge; a late bus_ack_i after reset release produces no mN_ack_o.
